// File: rtl/rv_pkg.sv
// Shared RV32I register-file constants and index type.
package rv_pkg;
  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;
  localparam int REG_ZERO = 0;
  localparam int REG_SP   = 2;
  localparam logic [31:0] SP_INIT = 32'h0000_8000;
  typedef logic [$clog2(NREG_DEF)-1:0] regidx_t;
endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: busy vector, RAW/WAW hazard detection and
// flush > issue > writeback-clear update priority.
module reg_scoreboard
  import rv_pkg::*;
#(
  parameter int NREG   = NREG_DEF,
  parameter int AW     = $clog2(NREG),
  parameter bit BYPASS = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [AW-1:0] rs1_addr,
  input  logic [AW-1:0] rs2_addr,
  input  logic          iss_en,
  input  logic [AW-1:0] iss_rd,
  input  logic          flush,
  output logic          rs1_busy,
  output logic          rs2_busy,
  output logic          iss_ok,
  output logic [NREG-1:0] busy_vec
);
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic [NREG-1:0] busy_eff;

  // A writeback landing this cycle hides the pending bit only when forwarding exists.
  for (genvar gi = 0; gi < NREG; gi++) begin : g_eff
    assign busy_eff[gi] = busy_q[gi] && !(BYPASS && wr_en && (wr_addr == AW'(gi)));
  end

  assign rs1_busy = busy_eff[rs1_addr];
  assign rs2_busy = busy_eff[rs2_addr];
  assign iss_ok   = !rs1_busy && !rs2_busy && !((iss_rd != '0) && busy_eff[iss_rd]);
  assign busy_vec = busy_q;

  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      if (wr_en && (wr_addr != '0)) busy_d[wr_addr] = 1'b0;
      if (iss_en && iss_ok && (iss_rd != '0)) busy_d[iss_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end
endmodule

// File: rtl/reg_file_sb.sv
// Integer register file with two combinational read ports, one write port,
// optional write-to-read forwarding and a pending-write scoreboard.
module reg_file_sb
  import rv_pkg::*;
#(
  parameter int          XLEN    = XLEN_DEF,
  parameter int          NREG    = NREG_DEF,
  parameter int          AW      = $clog2(NREG),
  parameter int          SP_IDX  = REG_SP,
  parameter logic [XLEN-1:0] SP_INIT = rv_pkg::SP_INIT,
  parameter bit          BYPASS  = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            iss_en,
  input  logic [AW-1:0]   iss_rd,
  output logic            iss_ok,
  input  logic            flush,
  output logic [NREG-1:0] busy_vec
);
  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic            wr_live;

  assign wr_live = wr_en && (wr_addr != '0);

  always_comb begin
    for (int i = 0; i < NREG; i++) regs_d[i] = regs_q[i];
    if (wr_live) regs_d[wr_addr] = wr_data;
    regs_d[REG_ZERO] = '0;
  end

  // Each register has its own reset value, so the array is built as flops.
  for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
    always_ff @(posedge clk or posedge reset) begin
      if (reset) regs_q[gi] <= (gi == SP_IDX) ? SP_INIT : '0;
      else       regs_q[gi] <= regs_d[gi];
    end
  end

  assign rs1_data = (BYPASS && wr_live && (wr_addr == rs1_addr)) ? wr_data : regs_q[rs1_addr];
  assign rs2_data = (BYPASS && wr_live && (wr_addr == rs2_addr)) ? wr_data : regs_q[rs2_addr];

  reg_scoreboard #(
    .NREG  (NREG),
    .AW    (AW),
    .BYPASS(BYPASS)
  ) u_sb (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .rs1_addr(rs1_addr),
    .rs2_addr(rs2_addr),
    .iss_en  (iss_en),
    .iss_rd  (iss_rd),
    .flush   (flush),
    .rs1_busy(rs1_busy),
    .rs2_busy(rs2_busy),
    .iss_ok  (iss_ok),
    .busy_vec(busy_vec)
  );
endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb; a BYPASS=1 and a BYPASS=0 instance share stimulus.
module tb_reg_file_sb;
  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  rs1_addr, rs2_addr;
  logic        iss_en;
  logic [4:0]  iss_rd;
  logic        flush;

  logic [31:0] a_rs1_data, a_rs2_data, b_rs1_data, b_rs2_data;
  logic        a_rs1_busy, a_rs2_busy, a_iss_ok, b_rs1_busy, b_rs2_busy, b_iss_ok;
  logic [31:0] a_busy_vec, b_busy_vec;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  reg_file_sb #(.BYPASS(1'b1)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(a_rs1_data), .rs2_data(a_rs2_data),
    .rs1_busy(a_rs1_busy), .rs2_busy(a_rs2_busy), .iss_en(iss_en), .iss_rd(iss_rd),
    .iss_ok(a_iss_ok), .flush(flush), .busy_vec(a_busy_vec)
  );

  reg_file_sb #(.BYPASS(1'b0)) dut_nb (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(b_rs1_data), .rs2_data(b_rs2_data),
    .rs1_busy(b_rs1_busy), .rs2_busy(b_rs2_busy), .iss_en(iss_en), .iss_rd(iss_rd),
    .iss_ok(b_iss_ok), .flush(flush), .busy_vec(b_busy_vec)
  );

  task automatic idle();
    wr_en = 0; wr_addr = 0; wr_data = 0; rs1_addr = 0; rs2_addr = 0;
    iss_en = 0; iss_rd = 0; flush = 0;
  endtask

  // Inputs change at the falling edge; outputs are sampled 1ns later.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1; idle(); rs1_addr = 2; rs2_addr = 5;
    #1;
    total++; if (a_rs1_data !== 32'h8000) begin bad++; $display("FAIL reset_sp got=%h exp=%h", a_rs1_data, 32'h8000); end
    total++; if (a_rs2_data !== 32'h0) begin bad++; $display("FAIL reset_x5 got=%h exp=0", a_rs2_data); end
    total++; if (a_busy_vec !== 32'h0) begin bad++; $display("FAIL reset_busy got=%h exp=0", a_busy_vec); end
    total++; if (a_iss_ok !== 1'b1) begin bad++; $display("FAIL reset_iss_ok got=%b exp=1", a_iss_ok); end
    step(); reset = 0;
    step();
    $display("test_reset done");
  endtask

  task automatic test_write_read();
    idle(); wr_en = 1; wr_addr = 5; wr_data = 32'hDEADBEEF;
    step(); idle(); rs1_addr = 5; #1;
    total++; if (a_rs1_data !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_x5 got=%h exp=deadbeef", a_rs1_data); end
    total++; if (b_rs1_data !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_x5_nb got=%h exp=deadbeef", b_rs1_data); end
    step(); idle(); wr_en = 1; wr_addr = 0; wr_data = 32'h1234; rs1_addr = 0; #1;
    total++; if (a_rs1_data !== 32'h0) begin bad++; $display("FAIL x0_bypass got=%h exp=0", a_rs1_data); end
    step(); idle(); rs1_addr = 0; #1;
    total++; if (a_rs1_data !== 32'h0) begin bad++; $display("FAIL x0_write got=%h exp=0", a_rs1_data); end
    total++; if (a_busy_vec !== 32'h0) begin bad++; $display("FAIL x0_busy got=%h exp=0", a_busy_vec); end
    $display("test_write_read done");
  endtask

  task automatic test_bypass();
    step(); idle(); wr_en = 1; wr_addr = 7; wr_data = 32'hA5A5A5A5; rs2_addr = 7; #1;
    total++; if (a_rs2_data !== 32'hA5A5A5A5) begin bad++; $display("FAIL bypass got=%h exp=a5a5a5a5", a_rs2_data); end
    total++; if (b_rs2_data !== 32'h0) begin bad++; $display("FAIL nobypass_old got=%h exp=0", b_rs2_data); end
    step(); idle(); rs2_addr = 7; #1;
    total++; if (b_rs2_data !== 32'hA5A5A5A5) begin bad++; $display("FAIL nobypass_after got=%h exp=a5a5a5a5", b_rs2_data); end
    $display("test_bypass done");
  endtask

  task automatic test_raw();
    step(); idle(); iss_en = 1; iss_rd = 3; #1;
    total++; if (a_iss_ok !== 1'b1) begin bad++; $display("FAIL raw_issue_ok got=%b exp=1", a_iss_ok); end
    step(); idle(); rs1_addr = 3; #1;
    total++; if (a_busy_vec !== 32'h8) begin bad++; $display("FAIL raw_busyvec got=%h exp=8", a_busy_vec); end
    total++; if (a_rs1_busy !== 1'b1) begin bad++; $display("FAIL raw_busy got=%b exp=1", a_rs1_busy); end
    total++; if (a_iss_ok !== 1'b0) begin bad++; $display("FAIL raw_stall got=%b exp=0", a_iss_ok); end
    wr_en = 1; wr_addr = 3; wr_data = 32'h33; #1;
    total++; if (a_rs1_busy !== 1'b0) begin bad++; $display("FAIL raw_wb_busy got=%b exp=0", a_rs1_busy); end
    total++; if (a_iss_ok !== 1'b1) begin bad++; $display("FAIL raw_wb_ok got=%b exp=1", a_iss_ok); end
    total++; if (b_rs1_busy !== 1'b1) begin bad++; $display("FAIL raw_wb_busy_nb got=%b exp=1", b_rs1_busy); end
    total++; if (b_iss_ok !== 1'b0) begin bad++; $display("FAIL raw_wb_ok_nb got=%b exp=0", b_iss_ok); end
    step(); idle(); rs1_addr = 3; #1;
    total++; if (b_busy_vec !== 32'h0) begin bad++; $display("FAIL raw_clear_nb got=%h exp=0", b_busy_vec); end
    total++; if (a_rs1_data !== 32'h33) begin bad++; $display("FAIL raw_data got=%h exp=33", a_rs1_data); end
    $display("test_raw done");
  endtask

  task automatic test_waw();
    step(); idle(); iss_en = 1; iss_rd = 4;
    step(); idle(); iss_en = 1; iss_rd = 4; #1;
    total++; if (a_iss_ok !== 1'b0) begin bad++; $display("FAIL waw_stall got=%b exp=0", a_iss_ok); end
    wr_en = 1; wr_addr = 4; wr_data = 32'h44; #1;
    total++; if (a_iss_ok !== 1'b1) begin bad++; $display("FAIL waw_wb_ok got=%b exp=1", a_iss_ok); end
    step(); idle(); #1;
    total++; if (a_busy_vec !== 32'h10) begin bad++; $display("FAIL waw_prio got=%h exp=10", a_busy_vec); end
    total++; if (b_busy_vec !== 32'h0) begin bad++; $display("FAIL waw_prio_nb got=%h exp=0", b_busy_vec); end
    wr_en = 1; wr_addr = 4; wr_data = 32'h45;
    step(); idle(); #1;
    total++; if (a_busy_vec !== 32'h0) begin bad++; $display("FAIL waw_clear got=%h exp=0", a_busy_vec); end
    $display("test_waw done");
  endtask

  task automatic test_flush();
    idle(); iss_en = 1; iss_rd = 1;
    step(); iss_rd = 3;
    step(); iss_rd = 9;
    step(); iss_rd = 0;
    step(); idle(); #1;
    total++; if (a_busy_vec !== 32'h20A) begin bad++; $display("FAIL flush_set got=%h exp=20a", a_busy_vec); end
    flush = 1; iss_en = 1; iss_rd = 10;
    step(); idle(); #1;
    total++; if (a_busy_vec !== 32'h0) begin bad++; $display("FAIL flush_clear got=%h exp=0", a_busy_vec); end
    $display("test_flush done");
  endtask

  task automatic test_async_reset();
    idle(); iss_en = 1; iss_rd = 6;
    step(); idle(); rs1_addr = 2; rs2_addr = 5; #1;
    total++; if (a_busy_vec !== 32'h40) begin bad++; $display("FAIL ar_pre_busy got=%h exp=40", a_busy_vec); end
    total++; if (a_rs2_data !== 32'hDEADBEEF) begin bad++; $display("FAIL ar_pre_x5 got=%h exp=deadbeef", a_rs2_data); end
    #1 reset = 1; #1;
    total++; if (a_rs1_data !== 32'h8000) begin bad++; $display("FAIL ar_sp got=%h exp=8000", a_rs1_data); end
    total++; if (a_rs2_data !== 32'h0) begin bad++; $display("FAIL ar_x5 got=%h exp=0", a_rs2_data); end
    total++; if (a_busy_vec !== 32'h0) begin bad++; $display("FAIL ar_busy got=%h exp=0", a_busy_vec); end
    #1 reset = 0;
    step(); idle(); wr_en = 1; wr_addr = 6; wr_data = 32'h66;
    step(); idle(); rs1_addr = 6; rs2_addr = 7; #1;
    total++; if (a_rs1_data !== 32'h66) begin bad++; $display("FAIL ar_wb_data got=%h exp=66", a_rs1_data); end
    total++; if (a_rs2_data !== 32'h0) begin bad++; $display("FAIL ar_x7 got=%h exp=0", a_rs2_data); end
    total++; if (a_busy_vec !== 32'h0) begin bad++; $display("FAIL ar_wb_busy got=%h exp=0", a_busy_vec); end
    $display("test_async_reset done");
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_raw();
    test_waw();
    test_flush();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
